// File: rtl/axi_pkg.sv
// axi_pkg
// Shared AXI4 encodings and the skid-buffer state type used by the
// axi_reg_slice pipeline stage.
//   - Burst encodings: BURST_FIXED / BURST_INCR / BURST_WRAP
//   - Response codes:  RESP_OKAY / RESP_EXOKAY / RESP_SLVERR / RESP_DECERR
//   - skid_state_t:    EMPTY / BUSY / FULL occupancy of one skid buffer
//   - slice_state_t:   per-channel skid states of a whole register slice
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Width of the AW/AR fields that are not ID or address:
  // len(8) + size(3) + burst(2) + lock(1) + cache(4) + prot(3) + qos(4) + region(4)
  localparam int AX_CTRL_WIDTH = 29;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // main register empty
    BUSY  = 2'd1,  // main register full, skid register empty
    FULL  = 2'd2   // main and skid registers full
  } skid_state_t;

  typedef struct packed {
    skid_state_t aw;
    skid_state_t w;
    skid_state_t b;
    skid_state_t ar;
    skid_state_t r;
  } slice_state_t;

endpackage

// File: rtl/axi_skid_buffer.sv
// axi_skid_buffer
// Two-entry fully registered valid/ready pipeline stage. Every output
// (in_ready, out_valid, out_data) comes straight from a flop, so there is no
// combinational path from either side to the other, while still sustaining
// one beat per cycle.
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   in_valid/in_ready/in_data     upstream side
//   out_valid/out_ready/out_data  downstream side
//   state                  current occupancy (EMPTY/BUSY/FULL)
// Handshake: a beat transfers on a rising edge where valid & ready are both
// high; the sender holds valid and data stable until that edge, and valid
// never depends on ready.
module axi_skid_buffer
  import axi_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output skid_state_t      state
);

  logic [WIDTH-1:0] skid_data;
  logic             in_hs;
  logic             out_hs;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  // out_data is the main register. in_ready is held low through reset and
  // rises on the first edge afterwards.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      case (state)
        EMPTY: begin
          in_ready <= 1'b1;
          if (in_hs) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (in_hs && !out_hs) begin
            // Downstream stalled while a beat arrived: park it in the skid.
            skid_data <= in_data;
            in_ready  <= 1'b0;
            state     <= FULL;
          end else if (out_hs && !in_hs) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end else if (in_hs && out_hs) begin
            out_data <= in_data;
          end
        end
        FULL: begin
          // in_ready is low here, so only the output side can move.
          if (out_hs) begin
            out_data <= skid_data;
            in_ready <= 1'b1;
            state    <= BUSY;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/axi_reg_slice.sv
// axi_reg_slice
// Full-register AXI4 pipeline stage placed upstream of ddr_slave_wrapper.
// Each of the five channels goes through its own axi_skid_buffer with the
// channel signals packed into one flat payload; payloads pass unmodified.
// AW, W, AR flow s_ -> m_; B, R flow m_ -> s_. Channels are independent.
// Ports:
//   aclk, aresetn   clock, asynchronous active-low reset
//   s_*             side facing the AXI master
//   m_*             side facing ddr_slave_wrapper
//   dbg_state       skid state of every channel
module axi_reg_slice
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  // slave-side AW
  input  logic [ID_WIDTH-1:0]     s_awid,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic [2:0]              s_awsize,
  input  logic [1:0]              s_awburst,
  input  logic                    s_awlock,
  input  logic [3:0]              s_awcache,
  input  logic [2:0]              s_awprot,
  input  logic [3:0]              s_awqos,
  input  logic [3:0]              s_awregion,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  // slave-side W
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  // slave-side B
  output logic [ID_WIDTH-1:0]     s_bid,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  // slave-side AR
  input  logic [ID_WIDTH-1:0]     s_arid,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [7:0]              s_arlen,
  input  logic [2:0]              s_arsize,
  input  logic [1:0]              s_arburst,
  input  logic                    s_arlock,
  input  logic [3:0]              s_arcache,
  input  logic [2:0]              s_arprot,
  input  logic [3:0]              s_arqos,
  input  logic [3:0]              s_arregion,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  // slave-side R
  output logic [ID_WIDTH-1:0]     s_rid,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  // master-side AW
  output logic [ID_WIDTH-1:0]     m_awid,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic                    m_awlock,
  output logic [3:0]              m_awcache,
  output logic [2:0]              m_awprot,
  output logic [3:0]              m_awqos,
  output logic [3:0]              m_awregion,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  // master-side W
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  // master-side B
  input  logic [ID_WIDTH-1:0]     m_bid,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  // master-side AR
  output logic [ID_WIDTH-1:0]     m_arid,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic                    m_arlock,
  output logic [3:0]              m_arcache,
  output logic [2:0]              m_arprot,
  output logic [3:0]              m_arqos,
  output logic [3:0]              m_arregion,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  // master-side R
  input  logic [ID_WIDTH-1:0]     m_rid,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  // observability
  output slice_state_t            dbg_state
);

  localparam int AX_W = ID_WIDTH + ADDR_WIDTH + AX_CTRL_WIDTH;
  localparam int W_W  = DATA_WIDTH + DATA_WIDTH / 8 + 1;
  localparam int B_W  = ID_WIDTH + 2;
  localparam int R_W  = ID_WIDTH + DATA_WIDTH + 3;

  logic [AX_W-1:0] aw_in, aw_out, ar_in, ar_out;
  logic [W_W-1:0]  w_in, w_out;
  logic [B_W-1:0]  b_in, b_out;
  logic [R_W-1:0]  r_in, r_out;

  skid_state_t aw_state, w_state, b_state, ar_state, r_state;

  // ---------------- AW ----------------
  assign aw_in = {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst,
                  s_awlock, s_awcache, s_awprot, s_awqos, s_awregion};
  assign {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst,
          m_awlock, m_awcache, m_awprot, m_awqos, m_awregion} = aw_out;

  axi_skid_buffer #(.WIDTH(AX_W)) u_aw (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (s_awvalid),
    .in_ready  (s_awready),
    .in_data   (aw_in),
    .out_valid (m_awvalid),
    .out_ready (m_awready),
    .out_data  (aw_out),
    .state     (aw_state)
  );

  // ---------------- W ----------------
  assign w_in = {s_wdata, s_wstrb, s_wlast};
  assign {m_wdata, m_wstrb, m_wlast} = w_out;

  axi_skid_buffer #(.WIDTH(W_W)) u_w (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (s_wvalid),
    .in_ready  (s_wready),
    .in_data   (w_in),
    .out_valid (m_wvalid),
    .out_ready (m_wready),
    .out_data  (w_out),
    .state     (w_state)
  );

  // ---------------- B (reverse) ----------------
  assign b_in = {m_bid, m_bresp};
  assign {s_bid, s_bresp} = b_out;

  axi_skid_buffer #(.WIDTH(B_W)) u_b (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (m_bvalid),
    .in_ready  (m_bready),
    .in_data   (b_in),
    .out_valid (s_bvalid),
    .out_ready (s_bready),
    .out_data  (b_out),
    .state     (b_state)
  );

  // ---------------- AR ----------------
  assign ar_in = {s_arid, s_araddr, s_arlen, s_arsize, s_arburst,
                  s_arlock, s_arcache, s_arprot, s_arqos, s_arregion};
  assign {m_arid, m_araddr, m_arlen, m_arsize, m_arburst,
          m_arlock, m_arcache, m_arprot, m_arqos, m_arregion} = ar_out;

  axi_skid_buffer #(.WIDTH(AX_W)) u_ar (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (s_arvalid),
    .in_ready  (s_arready),
    .in_data   (ar_in),
    .out_valid (m_arvalid),
    .out_ready (m_arready),
    .out_data  (ar_out),
    .state     (ar_state)
  );

  // ---------------- R (reverse) ----------------
  assign r_in = {m_rid, m_rdata, m_rresp, m_rlast};
  assign {s_rid, s_rdata, s_rresp, s_rlast} = r_out;

  axi_skid_buffer #(.WIDTH(R_W)) u_r (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (m_rvalid),
    .in_ready  (m_rready),
    .in_data   (r_in),
    .out_valid (s_rvalid),
    .out_ready (s_rready),
    .out_data  (r_out),
    .state     (r_state)
  );

  assign dbg_state = '{aw: aw_state, w: w_state, b: b_state, ar: ar_state, r: r_state};

endmodule

// File: tb/tb_axi_reg_slice.sv
// tb_axi_reg_slice
// Directed bench for axi_reg_slice: reset behaviour, a table of W-channel
// cycle vectors (streaming and back-pressure), AW payload pass-through, AR
// back-pressure ordering, R simultaneous handshake and B reset mid-operation.
module tb_axi_reg_slice;
  import axi_pkg::*;

  localparam int DW = 128;
  localparam int AW = 32;
  localparam int IW = 8;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------- DUT signals ----------------
  logic [IW-1:0] s_awid, s_arid, s_bid, s_rid, m_awid, m_arid, m_bid, m_rid;
  logic [AW-1:0] s_awaddr, s_araddr, m_awaddr, m_araddr;
  logic [7:0] s_awlen, s_arlen, m_awlen, m_arlen;
  logic [2:0] s_awsize, s_arsize, m_awsize, m_arsize;
  logic [1:0] s_awburst, s_arburst, m_awburst, m_arburst;
  logic s_awlock, s_arlock, m_awlock, m_arlock;
  logic [3:0] s_awcache, s_arcache, m_awcache, m_arcache;
  logic [2:0] s_awprot, s_arprot, m_awprot, m_arprot;
  logic [3:0] s_awqos, s_arqos, m_awqos, m_arqos;
  logic [3:0] s_awregion, s_arregion, m_awregion, m_arregion;
  logic s_awvalid, s_awready, m_awvalid, m_awready;
  logic s_arvalid, s_arready, m_arvalid, m_arready;
  logic [DW-1:0] s_wdata, m_wdata, s_rdata, m_rdata;
  logic [DW/8-1:0] s_wstrb, m_wstrb;
  logic s_wlast, m_wlast, s_wvalid, s_wready, m_wvalid, m_wready;
  logic [1:0] s_bresp, m_bresp, s_rresp, m_rresp;
  logic s_bvalid, s_bready, m_bvalid, m_bready;
  logic s_rlast, m_rlast, s_rvalid, s_rready, m_rvalid, m_rready;
  slice_state_t dbg_state;

  axi_reg_slice #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache), .s_awprot(s_awprot),
    .s_awqos(s_awqos), .s_awregion(s_awregion), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
    .s_arqos(s_arqos), .s_arregion(s_arregion), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
    .m_awqos(m_awqos), .m_awregion(m_awregion), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_arqos(m_arqos), .m_arregion(m_arregion), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .dbg_state(dbg_state)
  );

  logic [4:0] all_valid, all_ready;
  assign all_valid = {m_awvalid, m_wvalid, s_bvalid, m_arvalid, s_rvalid};
  assign all_ready = {s_awready, s_wready, m_bready, s_arready, m_rready};

  // ---------------- scoreboard / counters ----------------
  int n_chk = 0;
  int n_pass = 0;
  logic [47:0] exp_q[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // ---------------- W vector table ----------------
  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic       last;
    logic       mrdy;
    logic       exp_vld;
    logic [7:0] exp_data;
    logic       exp_last;
    logic       exp_srdy;
  } w_vec_t;

  w_vec_t w_tab[23];

  task automatic drive_w(input logic vld, input logic [7:0] data, input logic last, input logic mrdy);
    s_wvalid = vld;
    s_wdata  = {16{data}};
    s_wstrb  = {2{data}};
    s_wlast  = last;
    m_wready = mrdy;
  endtask

  task automatic idle_inputs();
    s_awvalid = 0; s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
    s_awlock = 0; s_awcache = '0; s_awprot = '0; s_awqos = '0; s_awregion = '0; m_awready = 0;
    s_arvalid = 0; s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    s_arlock = 0; s_arcache = '0; s_arprot = '0; s_arqos = '0; s_arregion = '0; m_arready = 0;
    drive_w(1'b0, 8'h00, 1'b0, 1'b0);
    m_bvalid = 0; m_bid = '0; m_bresp = '0; s_bready = 0;
    m_rvalid = 0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 0; s_rready = 0;
  endtask

  initial begin
    int idx;
    int n_out;
    logic [31:0] ar_addr[3];
    logic [47:0] got;

    idle_inputs();

    // Streaming: 16 beats 0x0..0xF with downstream always ready, then drain.
    for (int i = 0; i < 16; i++)
      w_tab[i] = '{1'b1, 8'(i), (i == 15), 1'b1, 1'b1, 8'(i), (i == 15), 1'b1};
    w_tab[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b1};
    // Back-pressure: two beats absorbed, third held off until release.
    w_tab[17] = '{1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b0, 1'b1};
    w_tab[18] = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b0, 1'b0};
    w_tab[19] = '{1'b1, 8'hA2, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0, 1'b0};
    w_tab[20] = '{1'b1, 8'hA2, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b1};
    w_tab[21] = '{1'b1, 8'hA2, 1'b1, 1'b1, 1'b1, 8'hA2, 1'b1, 1'b1};
    w_tab[22] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA2, 1'b1, 1'b1};

    // ---------------- reset ----------------
    for (int c = 0; c < 100; c++) begin
      tick();
      check("reset valids", all_valid, 5'b0);
      check("reset readies", all_ready, 5'b0);
    end
    aresetn = 1'b1;
    #1;
    check("readies before first edge", all_ready, 5'b0);
    tick();
    check("readies after release", all_ready, 5'b11111);
    check("valids after release", all_valid, 5'b0);
    check("payload reset", {m_awaddr, m_wdata, s_rdata}, '0);

    // ---------------- W table ----------------
    for (int i = 0; i < 23; i++) begin
      drive_w(w_tab[i].vld, w_tab[i].data, w_tab[i].last, w_tab[i].mrdy);
      #1;
      check($sformatf("w[%0d] s_wready pre", i), s_wready,
            (i == 0) ? 1'b1 : w_tab[i-1].exp_srdy);
      tick();
      check($sformatf("w[%0d] m_wvalid", i), m_wvalid, w_tab[i].exp_vld);
      check($sformatf("w[%0d] m_wdata", i), m_wdata, {16{w_tab[i].exp_data}});
      check($sformatf("w[%0d] m_wstrb", i), m_wstrb, {2{w_tab[i].exp_data}});
      check($sformatf("w[%0d] m_wlast", i), m_wlast, w_tab[i].exp_last);
      check($sformatf("w[%0d] s_wready", i), s_wready, w_tab[i].exp_srdy);
    end
    drive_w(1'b0, 8'h00, 1'b0, 1'b0);

    // ---------------- AW payload pass-through ----------------
    s_awid = 8'h5A; s_awaddr = 32'hDEAD_BEE0; s_awlen = 8'h09; s_awsize = 3'd4;
    s_awburst = BURST_WRAP; s_awlock = 1'b1; s_awcache = 4'hB; s_awprot = 3'd5;
    s_awqos = 4'hC; s_awregion = 4'h3; s_awvalid = 1'b1; m_awready = 1'b0;
    tick();
    s_awvalid = 1'b0;
    check("aw valid", m_awvalid, 1'b1);
    check("aw payload",
          {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot, m_awqos, m_awregion},
          {8'h5A, 32'hDEAD_BEE0, 8'h09, 3'd4, BURST_WRAP, 1'b1, 4'hB, 3'd5, 4'hC, 4'h3});
    check("aw state busy", dbg_state.aw, BUSY);
    m_awready = 1'b1;
    tick();
    check("aw drained", m_awvalid, 1'b0);
    check("aw state empty", dbg_state.aw, EMPTY);
    m_awready = 1'b0;

    // ---------------- AR back-pressure and ordering ----------------
    ar_addr[0] = 32'h100; ar_addr[1] = 32'h200; ar_addr[2] = 32'h300;
    idx = 0;
    n_out = 0;
    s_arvalid = 1'b1; s_araddr = ar_addr[0]; s_arid = 8'h01; s_arlen = 8'h00;
    s_arburst = BURST_INCR;
    for (int cyc = 0; cyc < 12; cyc++) begin
      m_arready = (cyc >= 3);
      @(negedge aclk);
      if (s_arvalid && s_arready) begin
        exp_q.push_back({s_arid, s_arlen, s_araddr});
        idx++;
      end
      if (m_arvalid && m_arready) begin
        got = {m_arid, m_arlen, m_araddr};
        n_out++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL ar extra beat: got %0h expected none", got);
        end else begin
          check("ar order", got, exp_q.pop_front());
        end
      end
      tick();
      if (cyc == 1) begin
        check("ar ready low after 2nd hs", s_arready, 1'b0);
        check("ar addr held 1", m_araddr, 32'h100);
        check("ar state full", dbg_state.ar, FULL);
      end
      if (cyc == 2) check("ar addr held 2", m_araddr, 32'h100);
      s_arvalid = (idx < 3);
      if (idx < 3) begin
        s_araddr = ar_addr[idx];
        s_arid   = 8'(idx + 1);
        s_arlen  = 8'(idx * 3);
      end
    end
    check("ar beats out", n_out, 3);
    check("ar queue empty", exp_q.size(), 0);
    m_arready = 1'b0;

    // ---------------- R simultaneous handshake in BUSY ----------------
    m_rvalid = 1'b1; m_rdata = {8{16'h1111}}; m_rid = 8'h04; m_rresp = RESP_OKAY; m_rlast = 1'b0;
    s_rready = 1'b0;
    tick();
    check("r busy", dbg_state.r, BUSY);
    check("r data 1", s_rdata, {8{16'h1111}});
    m_rdata = {8{16'h2222}}; m_rid = 8'h05; m_rresp = RESP_DECERR; m_rlast = 1'b1;
    s_rready = 1'b1;
    tick();
    check("r still busy", dbg_state.r, BUSY);
    check("r valid", s_rvalid, 1'b1);
    check("r data 2", {s_rid, s_rdata, s_rresp, s_rlast},
          {8'h05, {8{16'h2222}}, RESP_DECERR, 1'b1});
    check("r m_rready", m_rready, 1'b1);
    m_rvalid = 1'b0;
    tick();
    check("r drained", s_rvalid, 1'b0);
    s_rready = 1'b0;

    // ---------------- B full then reset mid-operation ----------------
    s_bready = 1'b0;
    m_bvalid = 1'b1; m_bid = 8'h01; m_bresp = RESP_SLVERR;
    tick();
    m_bid = 8'h02; m_bresp = RESP_EXOKAY;
    tick();
    m_bvalid = 1'b0;
    check("b full state", dbg_state.b, FULL);
    check("b m_bready low", m_bready, 1'b0);
    check("b head beat", {s_bvalid, s_bid, s_bresp}, {1'b1, 8'h01, RESP_SLVERR});
    #2;
    aresetn = 1'b0;
    #1;
    check("b valid cleared async", s_bvalid, 1'b0);
    check("readies cleared async", all_ready, 5'b0);
    check("b payload cleared", {s_bid, s_bresp}, '0);
    check("b state empty", dbg_state.b, EMPTY);
    tick();
    aresetn = 1'b1;
    s_bready = 1'b1;
    #1;
    check("b m_bready pre edge", m_bready, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("b no stale beat", s_bvalid, 1'b0);
      check("b m_bready up", m_bready, 1'b1);
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
